// File: rtl/count_extend_capture_pkg.sv
// Shared definitions for the count extension / capture block: default widths,
// the upstream counter's terminal value and the capture FSM state encoding.
package count_extend_capture_pkg;

    localparam int CNT_W_DEF = 4;
    localparam int EXT_W_DEF = 8;
    localparam int FULL_W    = EXT_W_DEF + CNT_W_DEF;

    // Terminal value of the upstream counter; a step from here to zero is a wrap.
    localparam logic [CNT_W_DEF-1:0] CNT_MAX = {CNT_W_DEF{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } cap_state_t;

endpackage

// File: rtl/count_extend_capture_step_check.sv
// Classifies each sampled upstream count against the previous sample:
// hold (unchanged), legal increment (flagging the max->0 wrap) or error.
import count_extend_capture_pkg::*;

module count_step_check #(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [CNT_W-1:0] count_in,
    input  logic             sample_en,
    output logic [CNT_W-1:0] prev_count,
    output logic             is_wrap,
    output logic             is_hold,
    output logic             is_err
);

    localparam logic [CNT_W-1:0] CNT_ALL1 = {CNT_W{1'b1}};

    logic [CNT_W-1:0] prev_count_q, prev_count_d;
    logic             prev_valid_q, prev_valid_d;
    logic [CNT_W-1:0] step_c;

    assign step_c     = prev_count_q + CNT_W'(1);
    assign prev_count = prev_count_q;

    // Step classification; nothing is flagged until a previous sample exists.
    always_comb begin
        is_wrap      = 1'b0;
        is_hold      = 1'b0;
        is_err       = 1'b0;
        prev_count_d = prev_count_q;
        prev_valid_d = prev_valid_q;
        if (sample_en) begin
            prev_count_d = count_in;
            prev_valid_d = 1'b1;
            if (prev_valid_q) begin
                if (count_in == prev_count_q) begin
                    is_hold = 1'b1;
                end else if (count_in == step_c) begin
                    is_wrap = (prev_count_q == CNT_ALL1);
                end else begin
                    is_err = 1'b1;
                end
            end
        end
    end

    // Previous-sample registers; an illegal step simply resyncs to the new value.
    always_ff @(posedge clock) begin
        if (clear) begin
            prev_count_q <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            prev_count_q <= prev_count_d;
            prev_valid_q <= prev_valid_d;
        end
    end

endmodule

// File: rtl/count_extend_capture.sv
// Extends a narrow upstream counter with a wrap counter, flags illegal steps,
// pulses on a programmable match and offers a valid/ready snapshot port.
import count_extend_capture_pkg::*;

module count_extend_capture #(
    parameter int CNT_W = CNT_W_DEF,
    parameter int EXT_W = EXT_W_DEF
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic [CNT_W-1:0]       count_in,
    input  logic                   sample_en,
    input  logic [EXT_W+CNT_W-1:0] match_val,
    input  logic                   cap_req,
    input  logic                   cap_ready,
    output logic                   cap_valid,
    output logic [EXT_W+CNT_W-1:0] cap_data,
    output logic [EXT_W-1:0]       ext_count,
    output logic                   match,
    output logic                   seq_err,
    output logic                   cap_overrun,
    output logic                   ext_ovf
);

    localparam int FW = EXT_W + CNT_W;

    logic [CNT_W-1:0] prev_count;
    logic             is_wrap, is_hold, is_err;

    logic [EXT_W-1:0] ext_count_q, ext_count_d;
    logic             ext_ovf_q, ext_ovf_d;
    logic             seq_err_q, seq_err_d;
    logic             match_q, match_d;
    logic [FW-1:0]    full_cur, full_next;

    cap_state_t       state_q;
    logic             cap_valid_q;
    logic [FW-1:0]    cap_data_q;
    logic             cap_overrun_q;

    count_step_check #(.CNT_W(CNT_W)) u_step (
        .clock      (clock),
        .clear      (clear),
        .count_in   (count_in),
        .sample_en  (sample_en),
        .prev_count (prev_count),
        .is_wrap    (is_wrap),
        .is_hold    (is_hold),
        .is_err     (is_err)
    );

    // Next extended value and flag updates; unsampled cycles keep the current value.
    always_comb begin
        ext_count_d = ext_count_q + EXT_W'(is_wrap);
        ext_ovf_d   = ext_ovf_q | (is_wrap & (ext_count_q == {EXT_W{1'b1}}));
        seq_err_d   = seq_err_q | is_err;
        full_cur    = {ext_count_q, prev_count};
        full_next   = sample_en ? {ext_count_d, count_in} : full_cur;
        // Pulse only on arrival at the compare value, never while sitting on it.
        match_d     = sample_en & ~is_hold & (full_next == match_val) & (full_next != full_cur);
    end

    // Wrap counter, sticky flags and registered match pulse.
    always_ff @(posedge clock) begin
        if (clear) begin
            ext_count_q <= '0;
            ext_ovf_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            match_q     <= 1'b0;
        end else begin
            ext_count_q <= ext_count_d;
            ext_ovf_q   <= ext_ovf_d;
            seq_err_q   <= seq_err_d;
            match_q     <= match_d;
        end
    end

    // Capture FSM: snapshot in IDLE, hold until transfer, reload back-to-back.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q       <= IDLE;
            cap_valid_q   <= 1'b0;
            cap_data_q    <= '0;
            cap_overrun_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cap_req) begin
                        cap_data_q  <= full_next;
                        cap_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (cap_ready) begin
                        if (cap_req) begin
                            cap_data_q  <= full_next;
                            cap_valid_q <= 1'b1;
                        end else begin
                            cap_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end else if (cap_req) begin
                        cap_overrun_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cap_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign ext_count   = ext_count_q;
    assign ext_ovf     = ext_ovf_q;
    assign seq_err     = seq_err_q;
    assign match       = match_q;
    assign cap_valid   = cap_valid_q;
    assign cap_data    = cap_data_q;
    assign cap_overrun = cap_overrun_q;

endmodule

// File: tb/tb_count_extend_capture.sv
// Bench for count_extend_capture: directed scenarios plus random traffic, with a
// wrap-counting reference model feeding a per-cycle queue and a capture queue.
module tb_count_extend_capture;
    import count_extend_capture_pkg::*;

    logic              clock = 1'b0;
    logic              clear, sample_en, cap_req, cap_ready;
    logic [3:0]        count_in;
    logic [FULL_W-1:0] match_val;
    logic              cap_valid, match, seq_err, cap_overrun, ext_ovf;
    logic [FULL_W-1:0] cap_data;
    logic [7:0]        ext_count;

    always #5 clock = ~clock;

    count_extend_capture #(.CNT_W(4), .EXT_W(8)) dut (
        .clock       (clock),
        .clear       (clear),
        .count_in    (count_in),
        .sample_en   (sample_en),
        .match_val   (match_val),
        .cap_req     (cap_req),
        .cap_ready   (cap_ready),
        .cap_valid   (cap_valid),
        .cap_data    (cap_data),
        .ext_count   (ext_count),
        .match       (match),
        .seq_err     (seq_err),
        .cap_overrun (cap_overrun),
        .ext_ovf     (ext_ovf)
    );

    typedef struct {
        logic [7:0]        ext;
        logic              mt, err, ovr, ovf, cv;
        logic [FULL_W-1:0] cd;
    } exp_t;

    exp_t              exp_q[$];
    logic [FULL_W-1:0] cap_q[$];
    int                errors = 0;
    int                checks = 0;

    // Reference model: total wrap count as a plain integer, previous sample, flags.
    bit m_pv, m_err, m_ovr, m_pend, m_match;
    int m_prev, m_wraps, m_snap;

    function automatic int mfull();
        return ((m_wraps % 256) * 16) + m_prev;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int   old_full, new_full;
        exp_t e;
        if (clear) begin
            m_pv = 0; m_prev = 0; m_wraps = 0; m_err = 0; m_ovr = 0;
            m_pend = 0; m_snap = 0; m_match = 0;
            cap_q.delete();
        end else begin
            old_full = mfull();
            if (sample_en) begin
                if (m_pv && int'(count_in) != m_prev) begin
                    if (int'(count_in) == (m_prev + 1) % 16) begin
                        if (m_prev == 15) m_wraps++;
                    end else begin
                        m_err = 1;
                    end
                end
                m_prev = int'(count_in);
                m_pv   = 1;
            end
            new_full = mfull();
            m_match  = sample_en && (new_full == int'(match_val)) && (new_full != old_full);
            if (!m_pend) begin
                if (cap_req) begin
                    m_pend = 1; m_snap = new_full; cap_q.push_back(FULL_W'(new_full));
                end
            end else if (cap_ready) begin
                if (cap_req) begin
                    m_snap = new_full; cap_q.push_back(FULL_W'(new_full));
                end else begin
                    m_pend = 0;
                end
            end else if (cap_req) begin
                m_ovr = 1;
            end
        end
        e.ext = 8'(m_wraps % 256);
        e.mt  = m_match;
        e.err = m_err;
        e.ovr = m_ovr;
        e.ovf = (m_wraps >= 256);
        e.cv  = m_pend;
        e.cd  = FULL_W'(m_snap);
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic ce, input logic [3:0] cin, input logic req, input logic rdy);
        clear = 1'b0; sample_en = ce; count_in = cin; cap_req = req; cap_ready = rdy;
        cyc();
    endtask

    task automatic do_clear();
        clear = 1'b1; sample_en = 1'b0; cap_req = 1'b0; cap_ready = 1'b0;
        cyc();
        clear = 1'b0;
    endtask

    // Monitor: compares every registered output and every capture transfer.
    initial begin
        exp_t              e;
        logic [FULL_W-1:0] c;
        forever begin
            @(negedge clock);
            if (clear === 1'b0 && cap_valid === 1'b1 && cap_ready === 1'b1) begin
                if (cap_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cap_xfer: transfer of %0h with no snapshot expected", cap_data);
                end else begin
                    c = cap_q.pop_front();
                    check("cap_xfer", cap_data, c);
                end
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ext_count", ext_count, e.ext);
                check("match", match, e.mt);
                check("seq_err", seq_err, e.err);
                check("cap_overrun", cap_overrun, e.ovr);
                check("ext_ovf", ext_ovf, e.ovf);
                check("cap_valid", cap_valid, e.cv);
                check("cap_data", cap_data, e.cd);
            end
        end
    end

    initial begin
        int         pulses;
        logic [3:0] rc;
        int         r;
        clear = 1'b1; sample_en = 1'b0; count_in = 4'd0; cap_req = 1'b0; cap_ready = 1'b0;
        match_val = '1;
        cyc();
        cyc();
        clear = 1'b0;
        check("rst_ext", ext_count, 0);
        check("rst_valid", cap_valid, 0);
        check("rst_data", cap_data, 0);
        check("rst_flags", {match, seq_err, cap_overrun, ext_ovf}, 0);
        drive(1'b1, 4'd5, 1'b0, 1'b0);
        check("first_sample_no_err", seq_err, 0);

        // Two wraps then a capture on the final sample.
        do_clear();
        for (int i = 0; i < 36; i++) drive(1'b1, 4'(i % 16), (i == 35), 1'b0);
        check("sweep_ext", ext_count, 2);
        check("sweep_cap_data", cap_data, 12'h023);
        check("sweep_cap_valid", cap_valid, 1);

        // 256 wraps roll the extension over and set the sticky overflow.
        do_clear();
        for (int i = 0; i <= 256 * 16; i++) drive(1'b1, 4'(i % 16), 1'b0, 1'b0);
        check("ovf_ext", ext_count, 0);
        check("ovf_flag", ext_ovf, 1);
        for (int i = 0; i < 3; i++) drive(1'b0, 4'd3, 1'b0, 1'b0);
        check("ovf_sticky", ext_ovf, 1);
        do_clear();
        check("ovf_cleared", ext_ovf, 0);

        // Hold, illegal jump, then legal step.
        drive(1'b1, 4'd6, 1'b0, 1'b0);
        drive(1'b1, 4'd6, 1'b0, 1'b0);
        check("hold_no_err", seq_err, 0);
        drive(1'b1, 4'd9, 1'b0, 1'b0);
        check("jump_err", seq_err, 1);
        drive(1'b1, 4'd10, 1'b0, 1'b0);
        check("jump_no_wrap", ext_count, 0);

        // Capture held under backpressure, dropped request, back-to-back reload.
        do_clear();
        for (int i = 0; i < 24; i++) drive(1'b1, 4'(i % 16), (i == 23), 1'b0);
        drive(1'b1, 4'd8, 1'b0, 1'b0);
        drive(1'b1, 4'd9, 1'b1, 1'b0);
        check("ovr_data_held", cap_data, 12'h017);
        check("ovr_flag", cap_overrun, 1);
        drive(1'b1, 4'd10, 1'b1, 1'b1);
        check("b2b_data", cap_data, 12'h01A);
        check("b2b_valid", cap_valid, 1);
        drive(1'b1, 4'd11, 1'b0, 1'b1);
        check("drain_valid", cap_valid, 0);

        // Match pulse on arrival at 0x010, none while paused there.
        do_clear();
        match_val = 12'h010;
        pulses = 0;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 4'(i % 16), 1'b0, 1'b0);
            if (match === 1'b1) pulses++;
        end
        check("match_after_010", match, 1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'd0, 1'b0, 1'b0);
            if (match === 1'b1) pulses++;
        end
        drive(1'b1, 4'd0, 1'b0, 1'b0);
        if (match === 1'b1) pulses++;
        for (int i = 1; i < 3; i++) begin
            drive(1'b1, 4'(i), 1'b0, 1'b0);
            if (match === 1'b1) pulses++;
        end
        check("match_pulses", pulses, 1);

        // Random traffic against the model.
        do_clear();
        rc = 4'd0;
        for (int n = 0; n < 800; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6) rc = rc + 4'd1;
            else if (r >= 8) rc = 4'($urandom);
            if ($urandom_range(0, 7) == 0) match_val = FULL_W'($urandom_range(0, 63));
            if ($urandom_range(0, 63) == 0) begin
                do_clear();
            end else begin
                drive(($urandom_range(0, 3) != 0), rc, ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 1) == 1));
            end
        end
        drive(1'b0, rc, 1'b0, 1'b0);
        @(negedge clock);
        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
